// File: rtl/prog_loader_pkg.sv
`default_nettype none
//============================================================================
// Module  : prog_loader_pkg
// Brief   : Shared word/address sizes and loader state encodings, common to
//           the program loader and the RAM block it feeds.
// Revision: 1.0 - initial release
//============================================================================

`ifndef WORDSIZE
`define WORDSIZE 8
`endif

`ifndef ADDRSIZE
`define ADDRSIZE 4
`endif

package prog_loader_pkg;

  // Loader state encodings
  typedef enum logic [1:0] {
    PL_IDLE  = 2'd0,
    PL_LOAD  = 2'd1,
    PL_CHECK = 2'd2,
    PL_DONE  = 2'd3
  } pl_state_t;

endpackage : prog_loader_pkg

`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
//============================================================================
// Module  : prog_loader
// Brief   : Streams LOAD_LEN program words into RAM through a valid/ready
//           port, holding the CPU in reset until the load completes.
//           Optional macro LOADER_CHECKSUM_EN adds a trailer-word checksum
//           check after the last data word.
// Revision: 1.0 - initial release
//============================================================================

`ifndef WORDSIZE
`define WORDSIZE 8
`endif

`ifndef ADDRSIZE
`define ADDRSIZE 4
`endif

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int LOAD_LEN = 16
) (
  input  logic                 pl_clk_i,
  input  logic                 pl_rst_i,
  input  logic                 pl_start_i,
  input  logic [`WORDSIZE-1:0] pl_data_i,
  input  logic                 pl_valid_i,
  output logic                 pl_ready_o,
  output logic                 pl_ram_we_o,
  output logic [`ADDRSIZE-1:0] pl_ram_addr_o,
  output logic [`WORDSIZE-1:0] pl_ram_data_o,
  output logic                 pl_busy_o,
  output logic                 pl_done_o,
  output logic                 pl_cpu_rst_o,
  output logic                 pl_err_o
);

  localparam logic [`ADDRSIZE-1:0] c_LAST_ADDR = `ADDRSIZE'(LOAD_LEN - 1);

  pl_state_t              r_state;
  pl_state_t              w_next;
  logic                   w_ready;
  logic                   w_busy;
  logic                   w_done;
  logic                   w_cpu_rst;
  logic                   w_hs;
  logic                   w_load_hs;
  logic                   w_start;
  logic [`ADDRSIZE-1:0]   r_addr;
  logic                   r_we;
  logic [`ADDRSIZE-1:0]   r_waddr;
  logic [`WORDSIZE-1:0]   r_wdata;

  assign w_hs      = pl_valid_i & w_ready;
  assign w_load_hs = w_hs && (r_state == PL_LOAD);
  // Start is only honoured when no load is in flight
  assign w_start   = pl_start_i && ((r_state == PL_IDLE) || (r_state == PL_DONE));

  // State register
  always_ff @(posedge pl_clk_i) begin
    if (pl_rst_i) r_state <= PL_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and status decode
  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_cpu_rst = 1'b1;
    case (r_state)
      PL_IDLE: begin
        if (pl_start_i) w_next = PL_LOAD;
      end
      PL_LOAD: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (pl_valid_i && (r_addr == c_LAST_ADDR)) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = PL_CHECK;
`else
          w_next = PL_DONE;
`endif
        end
      end
      PL_CHECK: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (pl_valid_i) w_next = PL_DONE;
      end
      PL_DONE: begin
        w_done    = 1'b1;
        w_cpu_rst = 1'b0;
        if (pl_start_i) w_next = PL_LOAD;
      end
      default: w_next = PL_IDLE;
    endcase
  end

  // Address counter and one-cycle-delayed RAM write port; reset drops any
  // write registered on the same edge
  always_ff @(posedge pl_clk_i) begin
    if (pl_rst_i) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_addr <= '0;
      end else if (w_load_hs) begin
        r_we    <= 1'b1;
        r_waddr <= r_addr;
        r_wdata <= pl_data_i;
        // Hold at the last address so the counter never wraps
        if (r_addr != c_LAST_ADDR) r_addr <= r_addr + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [`WORDSIZE-1:0] r_sum;
  logic                 r_err;

  // Running modulo sum of loaded words; trailer compared in CHECK
  always_ff @(posedge pl_clk_i) begin
    if (pl_rst_i) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (w_start) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (w_load_hs) begin
      r_sum <= r_sum + pl_data_i;
    end else if (w_hs && (r_state == PL_CHECK)) begin
      r_err <= (pl_data_i != r_sum);
    end
  end

  assign pl_err_o = r_err;
`else
  assign pl_err_o = 1'b0;
`endif

  assign pl_ready_o    = w_ready;
  assign pl_busy_o     = w_busy;
  assign pl_done_o     = w_done;
  assign pl_cpu_rst_o  = w_cpu_rst;
  assign pl_ram_we_o   = r_we;
  assign pl_ram_addr_o = r_waddr;
  assign pl_ram_data_o = r_wdata;

endmodule : prog_loader

`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
//============================================================================
// Module  : tb_prog_loader
// Brief   : Scoreboard bench for prog_loader (WORDSIZE=8, ADDRSIZE=4,
//           LOAD_LEN=4). Expected RAM writes are queued by the stimulus
//           and popped by a monitor on every write strobe.
// Revision: 1.0 - initial release
//============================================================================

module tb_prog_loader;

  localparam int LOAD_LEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       valid;
  logic [7:0] data;
  logic       pl_ready_o;
  logic       pl_ram_we_o;
  logic [3:0] pl_ram_addr_o;
  logic [7:0] pl_ram_data_o;
  logic       pl_busy_o;
  logic       pl_done_o;
  logic       pl_cpu_rst_o;
  logic       pl_err_o;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  logic [3:0]  exp_addr;
  logic [7:0]  words_a[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0]  words_b[4] = '{8'h01, 8'h02, 8'h03, 8'h04};

  always #5 clk = ~clk;

  prog_loader #(.LOAD_LEN(LOAD_LEN)) dut (
    .pl_clk_i      (clk),
    .pl_rst_i      (rst),
    .pl_start_i    (start),
    .pl_data_i     (data),
    .pl_valid_i    (valid),
    .pl_ready_o    (pl_ready_o),
    .pl_ram_we_o   (pl_ram_we_o),
    .pl_ram_addr_o (pl_ram_addr_o),
    .pl_ram_data_o (pl_ram_data_o),
    .pl_busy_o     (pl_busy_o),
    .pl_done_o     (pl_done_o),
    .pl_cpu_rst_o  (pl_cpu_rst_o),
    .pl_err_o      (pl_err_o)
  );

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (pl_ram_we_o === 1'b1) begin
      logic [11:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data 0x%02h, expected no write",
                 pl_ram_addr_o, pl_ram_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({pl_ram_addr_o, pl_ram_data_o} !== e) begin
          n_err++;
          $display("FAIL ram_write: got addr %0d data 0x%02h, expected addr %0d data 0x%02h",
                   pl_ram_addr_o, pl_ram_data_o, e[11:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one word and wait for it to be accepted
  task automatic send_word(input logic [7:0] d, input bit expect_write);
    bit ok;
    ok    = 1'b0;
    data  = d;
    valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pl_ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      if (expect_write) begin
        exp_q.push_back({exp_addr, d});
        exp_addr = exp_addr + 4'd1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_stream(input logic [7:0] w[4], input int gap);
    for (int i = 0; i < 4; i++) begin
      send_word(w[i], 1'b1);
      if (gap > 0) begin
        valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_trailer(input logic [7:0] t);
`ifdef LOADER_CHECKSUM_EN
    send_word(t, 1'b0);
    valid = 1'b0;
`else
    data = t;
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"},   {31'd0, pl_ready_o},    32'd0);
    check({tag, "_we"},      {31'd0, pl_ram_we_o},   32'd0);
    check({tag, "_addr"},    {28'd0, pl_ram_addr_o}, 32'd0);
    check({tag, "_data"},    {24'd0, pl_ram_data_o}, 32'd0);
    check({tag, "_busy"},    {31'd0, pl_busy_o},     32'd0);
    check({tag, "_done"},    {31'd0, pl_done_o},     32'd0);
    check({tag, "_err"},     {31'd0, pl_err_o},      32'd0);
    check({tag, "_cpu_rst"}, {31'd0, pl_cpu_rst_o},  32'd1);
  endtask

  task automatic check_done(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_pending"}, exp_q.size(),          32'd0);
    check({tag, "_done"},    {31'd0, pl_done_o},    32'd1);
    check({tag, "_cpu_rst"}, {31'd0, pl_cpu_rst_o}, 32'd0);
    check({tag, "_busy"},    {31'd0, pl_busy_o},    32'd0);
    check({tag, "_ready"},   {31'd0, pl_ready_o},   32'd0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    valid    = 1'b0;
    data     = 8'h00;
    exp_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Valid in IDLE must not write
    data  = 8'h5A;
    valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    valid = 1'b0;
    check("idle_ready", {31'd0, pl_ready_o}, 32'd0);

    // Back-to-back load
    pulse_start();
    exp_addr = 4'd0;
    check("load_busy",    {31'd0, pl_busy_o},    32'd1);
    check("load_ready",   {31'd0, pl_ready_o},   32'd1);
    check("load_cpu_rst", {31'd0, pl_cpu_rst_o}, 32'd1);
    check("load_done",    {31'd0, pl_done_o},    32'd0);
    send_stream(words_a, 0);
    send_trailer(8'hAA);
    check_done("b2b");
    check("b2b_err", {31'd0, pl_err_o}, 32'd0);

    // Restart from DONE with 3-cycle gaps between words
    pulse_start();
    exp_addr = 4'd0;
    check("restart_done", {31'd0, pl_done_o},    32'd0);
    check("restart_cpu",  {31'd0, pl_cpu_rst_o}, 32'd1);
    send_stream(words_a, 3);
    send_trailer(8'hAA);
    check_done("gap");

    // Start during LOAD is ignored
    pulse_start();
    exp_addr = 4'd0;
    send_word(words_a[0], 1'b1);
    send_word(words_a[1], 1'b1);
    valid = 1'b0;
    pulse_start();
    check("midstart_busy", {31'd0, pl_busy_o}, 32'd1);
    check("midstart_done", {31'd0, pl_done_o}, 32'd0);
    send_word(words_a[2], 1'b1);
    send_word(words_a[3], 1'b1);
    valid = 1'b0;
    send_trailer(8'hAA);
    check_done("midstart");

    // Reset after two words aborts, dropping the write of the third
    pulse_start();
    exp_addr = 4'd0;
    send_word(words_a[0], 1'b1);
    send_word(words_a[1], 1'b1);
    data  = words_a[2];
    valid = 1'b1;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    check_reset_state("abort");
    repeat (3) @(posedge clk);
    #1;
    check("abort_pending", exp_q.size(), 32'd0);
    check("abort_cpu_rst", {31'd0, pl_cpu_rst_o}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Correct trailer
    pulse_start();
    exp_addr = 4'd0;
    send_stream(words_b, 0);
    check("chk_state_busy", {31'd0, pl_busy_o}, 32'd1);
    send_trailer(8'h0A);
    check_done("chk_good");
    check("chk_good_err", {31'd0, pl_err_o}, 32'd0);

    // Wrong trailer
    pulse_start();
    exp_addr = 4'd0;
    send_stream(words_b, 0);
    send_trailer(8'h0B);
    check_done("chk_bad");
    check("chk_bad_err", {31'd0, pl_err_o}, 32'd1);

    // Restart clears the error flag
    pulse_start();
    check("chk_restart_err", {31'd0, pl_err_o}, 32'd0);
    exp_addr = 4'd0;
    send_stream(words_b, 0);
    send_trailer(8'h0A);
    check_done("chk_after");
`endif

    repeat (2) @(posedge clk);
    #1;
    check("final_pending", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_prog_loader

`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: LOAD_LEN, default 16, number of words written to RAM per load (1..2**`ADDRSIZE).
REQ-002 Port: pl_clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 Port: pl_rst_i  input  1  reset, synchronous, active-high.
REQ-004 Port: pl_start_i  input  1  pulse, begins a load.
REQ-005 Port: pl_data_i  input  `WORDSIZE  incoming program word.
REQ-006 Port: pl_valid_i  input  1  pl_data_i valid.
REQ-007 Port: pl_ready_o  output  1  loader accepts a word this cycle.
REQ-008 Port: pl_ram_we_o  output  `1`  write enable to RAM (drives ram_we_i).
REQ-009 Port: pl_ram_addr_o  output  `ADDRSIZE  RAM address (drives ram_addr_i).
REQ-010 Port: pl_ram_data_o  output  `WORDSIZE  RAM write data (drives ram_data_i).
REQ-011 Port: pl_busy_o  output  1  load in progress.
REQ-012 Port: pl_done_o  output  1  sticky; last load completed.
REQ-013 Port: pl_cpu_rst_o  output  1  holds CPU in reset while not done.
REQ-014 Port: pl_err_o  output  1  checksum mismatch (see Configuration).

Function
REQ-015 States SHALL be IDLE, LOAD, CHECK, DONE.
REQ-016 IDLE -> LOAD on pl_start_i; address counter SHALL clear to 0.
REQ-017 pl_ready_o SHALL be 1 only in LOAD and CHECK; handshake = pl_valid_i & pl_ready_o.
REQ-018 In LOAD, each handshake SHALL register a write: next cycle pl_ram_we_o=1 for exactly one cycle, pl_ram_addr_o=counter, pl_ram_data_o=accepted word (latency 1).
REQ-019 Counter SHALL increment per handshake; handshake at address LOAD_LEN-1 SHALL leave LOAD (to CHECK if LOADER_CHECKSUM_EN, else DONE); no address wrap or overwrite.
REQ-020 pl_valid_i low SHALL stall without changing counter or issuing writes.
REQ-021 DONE: pl_done_o=1, pl_busy_o=0, pl_cpu_rst_o=0; pl_start_i in DONE SHALL restart (-> LOAD, pl_done_o=0, pl_err_o=0, pl_cpu_rst_o=1).
REQ-022 pl_start_i in LOAD or CHECK SHALL be ignored.
REQ-023 pl_busy_o=1 in LOAD and CHECK; pl_cpu_rst_o=1 in every state except DONE.
REQ-024 pl_ram_we_o SHALL be 0 outside the single cycle after a LOAD handshake.

Reset
REQ-025 pl_rst_i SHALL, at the clock edge, force IDLE, counter=0, pl_ready_o=0, pl_ram_we_o=0, pl_ram_addr_o=0, pl_ram_data_o=0, pl_busy_o=0, pl_done_o=0, pl_err_o=0, pl_cpu_rst_o=1.
REQ-026 Reset mid-load SHALL abort with no further RAM writes, including any write registered that same cycle.

Configuration
REQ-027 Macro LOADER_CHECKSUM_EN defined: loader keeps a `WORDSIZE-bit modulo-2**`WORDSIZE sum of LOAD-accepted words; CHECK accepts one trailer word (no RAM write), sets pl_err_o=(trailer != sum), goes DONE.
REQ-028 Macro undefined: no sum logic, CHECK unreachable, pl_err_o tied 0.

Structure
REQ-029 `WORDSIZE, `ADDRSIZE and state encodings SHALL live in defines.h, shared with the RAM block.
REQ-030 Single module; no sub-module (optional checksum accumulator inline under the macro).
REQ-031 Outputs pl_ram_* SHALL connect directly to the RAM's data, write-enable and address inputs.

Verification (WORDSIZE=8, ADDRSIZE=4, LOAD_LEN=4)
REQ-032 Start, stream 0x11,0x22,0x33,0x44 back-to-back -> writes addr0..3 with those data, one we pulse each, pl_done_o=1, pl_cpu_rst_o=0.
REQ-033 Same stream with pl_valid_i low 3 cycles between words -> identical RAM writes, no extra we pulses.
REQ-034 Reset asserted after 2 words -> exactly 2 writes seen, outputs at reset values, pl_cpu_rst_o=1.
REQ-035 pl_start_i pulsed during LOAD -> ignored, counter unchanged; start in DONE -> new load from addr0.
REQ-036 LOADER_CHECKSUM_EN: words 0x01,0x02,0x03,0x04 + trailer 0x0A -> pl_err_o=0; trailer 0x0B -> pl_err_o=1; trailer not written to RAM.
